// File: rtl/timer_countdown_pkg.sv
// timer_countdown_pkg: state encoding and default widths shared by the timer blocks.
package timer_countdown_pkg;
    localparam int DEFAULT_DATA_WIDTH     = 16;
    localparam int DEFAULT_PRESCALE_WIDTH = 8;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: enabled clock divider emitting a tick every prescale_i+1 enabled clocks.
module timer_prescaler
    import timer_countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] prescale_i,
    output logic             tick_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    // >= rather than == so a prescale lowered mid-period ticks immediately
    assign tick_o = en_i && (cnt_q >= prescale_i);
    always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/timer_countdown.sv
// timer_countdown: prescaled down-counter with one-shot/periodic reload, TC strobe and sticky expired flag.
module timer_countdown
    import timer_countdown_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      LOAD,
    input  logic [DATA_WIDTH-1:0]     LOAD_VALUE,
    input  logic                      START,
    input  logic                      STOP,
    input  logic                      AUTO_RELOAD,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      CLEAR_EXPIRED,
    output logic [DATA_WIDTH-1:0]     DATA,
    output logic                      RUNNING,
    output logic                      TC,
    output logic                      EXPIRED
);
    state_e                state_q;
    logic [DATA_WIDTH-1:0] count_q, reload_q;
    logic                  tc_q, expired_q, tick;

    timer_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
        .clk_i      (CLOCK),
        .rst_i      (RESET),
        .en_i       (state_q == ST_RUN),
        .clr_i      (LOAD | START | STOP),
        .prescale_i (PRESCALE),
        .tick_o     (tick)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            tc_q      <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (CLEAR_EXPIRED) expired_q <= 1'b0;
            if (LOAD) begin
                reload_q <= LOAD_VALUE;
                count_q  <= LOAD_VALUE;
                if (LOAD_VALUE == '0 || STOP) state_q <= ST_IDLE;
                else if (START)               state_q <= ST_RUN;
            end else if (STOP) begin
                state_q <= ST_IDLE;
            end else if (START) begin
                if (state_q == ST_IDLE && count_q != '0) begin
                    state_q <= ST_RUN;
                end else if (state_q == ST_IDLE && reload_q != '0) begin
                    count_q <= reload_q;
                    state_q <= ST_RUN;
                end
            end else if (tick) begin
                // expiry: later set of expired_q overrides a coincident clear
                if (count_q == DATA_WIDTH'(1)) begin
                    tc_q      <= 1'b1;
                    expired_q <= 1'b1;
                    count_q   <= (AUTO_RELOAD && reload_q != '0) ? reload_q : '0;
                    state_q   <= (AUTO_RELOAD && reload_q != '0) ? ST_RUN : ST_IDLE;
                end else if (count_q != '0) begin
                    count_q <= count_q - 1'b1;
                end else begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign DATA    = count_q;
    assign RUNNING = (state_q == ST_RUN);
    assign TC      = tc_q;
    assign EXPIRED = expired_q;
endmodule

// File: tb/tb_timer_countdown.sv
// tb_timer_countdown: directed vectors with hand-computed expectations for timer_countdown.
module tb_timer_countdown;
    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        LOAD = 1'b0;
    logic [15:0] LOAD_VALUE = '0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        AUTO_RELOAD = 1'b0;
    logic [7:0]  PRESCALE = '0;
    logic        CLEAR_EXPIRED = 1'b0;
    logic [15:0] DATA;
    logic        RUNNING, TC, EXPIRED;
    int          checks = 0;
    int          errors = 0;

    timer_countdown dut (
        .CLOCK(CLOCK), .RESET(RESET), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE),
        .START(START), .STOP(STOP), .AUTO_RELOAD(AUTO_RELOAD), .PRESCALE(PRESCALE),
        .CLEAR_EXPIRED(CLEAR_EXPIRED), .DATA(DATA), .RUNNING(RUNNING), .TC(TC), .EXPIRED(EXPIRED)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        LOAD = 1'b1; LOAD_VALUE = v; cyc(); LOAD = 1'b0;
    endtask

    task automatic do_start();
        START = 1'b1; cyc(); START = 1'b0;
    endtask

    task automatic do_stop();
        STOP = 1'b1; cyc(); STOP = 1'b0;
    endtask

    task automatic do_clear();
        CLEAR_EXPIRED = 1'b1; cyc(); CLEAR_EXPIRED = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        RESET = 1'b0;
        chk("rst_data", DATA, 0);
        chk("rst_run", RUNNING, 0);
        chk("rst_tc", TC, 0);
        chk("rst_exp", EXPIRED, 0);

        // one-shot, prescale 0
        do_load(16'd5);
        chk("t1_load_data", DATA, 5);
        chk("t1_load_run", RUNNING, 0);
        do_start();
        chk("t1_start_data", DATA, 5);
        chk("t1_start_run", RUNNING, 1);
        for (int i = 4; i >= 1; i--) begin
            cyc();
            chk("t1_data", DATA, i);
            chk("t1_tc_lo", TC, 0);
        end
        cyc();
        chk("t1_exp_data", DATA, 0);
        chk("t1_exp_tc", TC, 1);
        chk("t1_exp_run", RUNNING, 0);
        chk("t1_exp_flag", EXPIRED, 1);
        cyc();
        chk("t1_tc_once", TC, 0);
        chk("t1_exp_sticky", EXPIRED, 1);
        chk("t1_hold_data", DATA, 0);
        do_clear();
        chk("t1_exp_clr", EXPIRED, 0);

        // periodic, prescale 2: decrement every 3 clocks, TC every 9
        AUTO_RELOAD = 1'b1; PRESCALE = 8'd2;
        do_load(16'd3);
        do_start();
        chk("t2_start_data", DATA, 3);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk("t2_data", DATA, 3 - ((k / 3) % 3));
            chk("t2_tc", TC, (k % 9 == 0) ? 1 : 0);
            chk("t2_run", RUNNING, 1);
        end
        do_stop();
        chk("t2_stop_run", RUNNING, 0);
        do_clear();

        // stop / resume
        AUTO_RELOAD = 1'b0; PRESCALE = 8'd0;
        do_load(16'd10);
        do_start();
        for (int i = 9; i >= 6; i--) begin
            cyc();
            chk("t3_data", DATA, i);
        end
        do_stop();
        chk("t3_stop_data", DATA, 6);
        chk("t3_stop_run", RUNNING, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_hold", DATA, 6);
        end
        do_start();
        chk("t3_resume_data", DATA, 6);
        chk("t3_resume_run", RUNNING, 1);
        for (int i = 5; i >= 1; i--) begin
            cyc();
            chk("t3_data2", DATA, i);
            chk("t3_tc_lo", TC, 0);
        end
        cyc();
        chk("t3_tc", TC, 1);
        chk("t3_end_data", DATA, 0);
        do_clear();

        // LOAD+STOP together, then LOAD 0 while running
        do_load(16'd10);
        do_start();
        cyc(); cyc(); cyc();
        chk("t4_at7", DATA, 7);
        LOAD = 1'b1; LOAD_VALUE = 16'd100; STOP = 1'b1;
        cyc();
        LOAD = 1'b0; STOP = 1'b0;
        chk("t4_ls_data", DATA, 100);
        chk("t4_ls_run", RUNNING, 0);
        do_start();
        chk("t4_run", RUNNING, 1);
        cyc();
        chk("t4_dec", DATA, 99);
        do_load(16'd0);
        chk("t4_l0_data", DATA, 0);
        chk("t4_l0_run", RUNNING, 0);
        chk("t4_l0_tc", TC, 0);
        cyc();
        chk("t4_l0_tc2", TC, 0);
        chk("t4_l0_exp", EXPIRED, 0);

        // reset mid-count, then START with reload 0
        do_load(16'd5);
        do_start();
        cyc(); cyc(); cyc();
        chk("t5_at2", DATA, 2);
        RESET = 1'b1; cyc(); RESET = 1'b0;
        chk("t5_rst_data", DATA, 0);
        chk("t5_rst_run", RUNNING, 0);
        chk("t5_rst_tc", TC, 0);
        chk("t5_rst_exp", EXPIRED, 0);
        cyc();
        chk("t5_rst_tc2", TC, 0);
        do_start();
        chk("t5_nostart_run", RUNNING, 0);
        chk("t5_nostart_data", DATA, 0);

        // expiry coinciding with clear, then restart from reload at count 0
        do_load(16'd4);
        do_start();
        cyc(); cyc(); cyc();
        chk("t6_at1", DATA, 1);
        CLEAR_EXPIRED = 1'b1; cyc(); CLEAR_EXPIRED = 1'b0;
        chk("t6_tc", TC, 1);
        chk("t6_set_wins", EXPIRED, 1);
        chk("t6_idle", RUNNING, 0);
        do_start();
        chk("t6_reload_data", DATA, 4);
        chk("t6_reload_run", RUNNING, 1);
        do_stop();

        // LOAD+START together
        LOAD = 1'b1; LOAD_VALUE = 16'd3; START = 1'b1;
        cyc();
        LOAD = 1'b0; START = 1'b0;
        chk("t7_data", DATA, 3);
        chk("t7_run", RUNNING, 1);
        cyc();
        chk("t7_dec", DATA, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
